spi_adc_sampler: RTL and testbench
==================================

// Module: spi_adc_sampler
// PURPOSE
// - Producer end of the sample_valid/value stream consumed by the motion classifier.
// - Acts as SPI master to a 12-bit serial ADC (16-clock frame, 4 leading zeros, MSB first).
// - Converts each offset-binary reading to signed 12-bit and emits it as a one-cycle pulse
//   at a programmable sample rate.
// PARAMETERS
// - CLK_DIV        default 4     clk cycles per sclk half-period (>=1)
// - SAMPLE_PERIOD  default 1000  clk cycles between conversion starts (>= 34*CLK_DIV+2)
// PORTS
// - clk           in   1   system clock, all logic on posedge
// - rst_n         in   1   reset, asynchronous, active-low
// - enable        in   1   run sampling when high
// - miso          in   1   ADC serial data
// - sclk          out  1   SPI clock, idles high
// - cs_n          out  1   ADC chip select, active-low
// - sample_valid  out  1   one-cycle pulse: value updated this cycle
// - value         out  12  signed sample; holds between pulses
// - busy          out  1   high while a frame is in progress (cs_n low)
// - frame_err     out  1   one-cycle pulse: frame rejected
// BEHAVIOUR
// - Reset (async, rst_n=0): sclk=1, cs_n=1, sample_valid=0, value=0, busy=0, frame_err=0.
//   The FSM goes to IDLE and the period counter is cleared. A frame in progress is aborted
//   immediately with no pulse.
// - Period counter: held at 0 while enable=0.
//   - While enable=1 it counts 0..SAMPLE_PERIOD-1 and wraps.
//   - The tick at SAMPLE_PERIOD-1 starts a frame if the FSM is IDLE; otherwise the tick is
//     dropped.
// - FSM states: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
//   - SETUP: cs_n=0, sclk=1 for CLK_DIV cycles.
//   - SHIFT: 16 sclk periods. Each period is sclk=0 for CLK_DIV cycles, then sclk=1 for
//     CLK_DIV cycles. miso is captured into a 16-bit shift register on the clk edge that
//     drives sclk 0->1.
//   - After the 16th high phase, cs_n=1 and the FSM enters DONE for exactly 1 cycle.
// - Frame timing: cs_n is low for exactly 33*CLK_DIV cycles. busy equals ~cs_n.
// - DONE cycle:
//   - If shift[15:12]==0: sample_valid=1 and value={~shift[11], shift[10:0]}
//     (raw-2048: 0x800->0, 0xFFF->+2047, 0x000->-2048).
//   - Otherwise: frame_err=1, sample_valid=0, and value holds.
//   - sample_valid and frame_err are never both high.
// - If enable falls mid-frame, the frame completes and emits normally. No further frame
//   starts, and cs_n stays high.
// - If enable rises, the first frame starts SAMPLE_PERIOD cycles later.
// - Arithmetic: conversion is a pure bit operation with no saturation. The counters are
//   sized by $clog2 of their parameter.
// CONFIGURATION
// - SAMPLE_AVG4_EN defined:
//   - A 14-bit accumulator sums raw (unsigned) values of valid frames.
//   - After the 4th valid frame: value = convert(sum[13:2]), sample_valid pulses, and the
//     accumulator and count clear.
//   - Frames 1-3 produce no pulse.
//   - A frame_err clears the accumulator and count.
//   - reset clears both.
// - SAMPLE_AVG4_EN undefined: every valid frame emits (behaviour above). No accumulator
//   logic is present.
// TESTING (CLK_DIV=2, SAMPLE_PERIOD=100, behavioural ADC model drives miso on sclk fall)
// - Reset then enable=1 with ADC raw 0x800 -> cs_n falls at enable+100 and stays low 66
//   cycles; 1-cycle sample_valid with value=0; all reset values checked.
// - Raw 0xFFF, 0x000, 0x814 on successive frames -> value +2047, -2048, +20; frames start
//   100 cycles apart.
// - Frame word 0x1ABC (leading bit set) -> frame_err 1-cycle pulse, no sample_valid, value
//   keeps previous.
// - enable=0 during SHIFT bit 5 -> frame finishes, one sample_valid, then cs_n=1 and sclk=1
//   for 300+ cycles.
// - rst_n=0 during SHIFT -> cs_n=1, sclk=1, busy=0 before the next clk edge; no pulse; after
//   release the first frame starts 100 cycles later.
// - SAMPLE_AVG4_EN: raws 0x800, 0x804, 0x808, 0x80C -> a single sample_valid after the 4th
//   frame, value=+6; an injected frame_err after the 2nd restarts the 4-count.

Source files
------------

// File: rtl/spi_adc_sampler.sv
// rtl/spi_adc_sampler.sv - SPI master for a 12-bit serial ADC, emits signed samples at a fixed rate
// Optional: define SAMPLE_AVG4_EN to emit the average of every four valid frames.
module spi_adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic        sample_valid,
  output logic [11:0] value,
  output logic        busy,
  output logic        frame_err
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             half_hi;
  logic [3:0]       bit_cnt;
  logic [15:0]      shift;
  logic             tick, div_last, frame_end, frame_ok;

  // Offset-binary to two's complement is just an MSB flip.
  function automatic logic [11:0] convert(input logic [11:0] raw);
    return {~raw[11], raw[10:0]};
  endfunction

  assign tick      = enable && (per_cnt == PER_LAST);
  assign div_last  = (div_cnt == DIV_LAST);
  assign frame_end = (state == SHIFT) && half_hi && div_last && (bit_cnt == 4'd15);
  assign frame_ok  = (shift[15:12] == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!enable || per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cs_n     = 1'b1;
    sclk     = 1'b1;
    case (state)
      IDLE:  if (tick) state_nx = SETUP;
      SETUP: begin
        cs_n = 1'b0;
        if (div_last) state_nx = SHIFT;
      end
      SHIFT: begin
        cs_n = 1'b0;
        sclk = half_hi;
        if (frame_end) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = ~cs_n;

  // miso is sampled on the edge that ends a low phase, i.e. the one raising sclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      half_hi <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if ((state == SETUP || state == SHIFT) && !div_last) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
      end
      if (state != SHIFT) begin
        half_hi <= 1'b0;
        bit_cnt <= '0;
      end else if (div_last) begin
        half_hi <= ~half_hi;
        if (half_hi) begin
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          shift <= {shift[14:0], miso};
        end
      end
    end
  end

`ifdef SAMPLE_AVG4_EN
  logic [13:0] acc, acc_sum;
  logic [1:0]  avg_cnt;

  assign acc_sum = acc + {2'b00, shift[11:0]};
`endif

  // Results register on the SHIFT->DONE edge so the pulse coincides with the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      value        <= '0;
`ifdef SAMPLE_AVG4_EN
      acc          <= '0;
      avg_cnt      <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (frame_end) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
`ifdef SAMPLE_AVG4_EN
          acc       <= '0;
          avg_cnt   <= '0;
`endif
        end else begin
`ifdef SAMPLE_AVG4_EN
          if (avg_cnt == 2'd3) begin
            value        <= convert(acc_sum[13:2]);
            sample_valid <= 1'b1;
            acc          <= '0;
            avg_cnt      <= '0;
          end else begin
            acc     <= acc_sum;
            avg_cnt <= avg_cnt + 2'd1;
          end
`else
          value        <= convert(shift[11:0]);
          sample_valid <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_sampler.sv
// tb/tb_spi_adc_sampler.sv - scoreboard bench for spi_adc_sampler with a behavioural serial ADC
module tb_spi_adc_sampler;
  typedef struct packed {
    logic        err;
    logic        ok;
    logic [11:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        miso = 1'b0;
  logic        sclk, cs_n, sample_valid, busy, frame_err;
  logic [11:0] value;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_fall = 0;
  int   low_run = 0;
  int   last_low = 0;
  int   both_hi = 0;
  logic cs_prev = 1'b1;
  logic [15:0] adc_word = 16'h0800;
  int   bit_idx = 15;
  ev_t  ev_q[$];
  ev_t  exp_q[$];

  spi_adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .miso(miso), .sclk(sclk), .cs_n(cs_n),
    .sample_valid(sample_valid), .value(value), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // ADC: frame starts on cs_n fall, next bit driven on each sclk fall, MSB first.
  always @(negedge cs_n or negedge sclk) begin
    if (sclk) begin
      bit_idx = 15;
    end else if (!cs_n && bit_idx >= 0) begin
      miso = adc_word[bit_idx];
      bit_idx--;
    end
  end

  task automatic step();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (cs_prev && !cs_n) last_fall = cyc;
    if (!cs_n) begin
      low_run++;
    end else if (low_run != 0) begin
      last_low = low_run;
      low_run = 0;
    end
    if (sample_valid && frame_err) both_hi++;
    if (sample_valid || frame_err) begin
      e.err = frame_err;
      e.ok  = sample_valid;
      e.val = value;
      ev_q.push_back(e);
    end
    cs_prev = cs_n;
  endtask

  task automatic wait_event(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (ev_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cs(input logic level, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (cs_n == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    tests++;
    if ({sclk, cs_n, sample_valid, busy, frame_err} !== 5'b11000) begin
      fails++;
      $display("FAIL reset_ctrl got sclk,cs_n,valid,busy,err=%b want 11000",
               {sclk, cs_n, sample_valid, busy, frame_err});
    end
    tests++;
    if (value !== 12'h000) begin
      fails++;
      $display("FAIL reset_value got %h want 000", value);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_first_frame();
    bit ok;
    ev_t got, exp;
    int en_cyc;
    adc_word = 16'h0800;
    exp_q.push_back('{err: 1'b0, ok: 1'b1, val: 12'h000});
    enable = 1'b1;
    en_cyc = cyc;
    wait_event(300, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL first_timeout no sample within 300 cycles");
      return;
    end
    got = ev_q.pop_front();
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL first_event got %h want %h", got, exp);
    end
    tests++;
    if (last_fall - en_cyc !== 100) begin
      fails++;
      $display("FAIL first_start got %0d want 100", last_fall - en_cyc);
    end
    tests++;
    if (last_low !== 66) begin
      fails++;
      $display("FAIL cs_low_len got %0d want 66", last_low);
    end
    step();
    tests++;
    if (sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_width got %b want 0", sample_valid);
    end
  endtask

  task automatic test_values();
    logic [15:0] words[3] = '{16'h0FFF, 16'h0000, 16'h0814};
    logic [11:0] vals[3]  = '{12'h7FF, 12'h800, 12'h014};
    bit ok;
    ev_t got, exp;
    int prev;
    for (int i = 0; i < 3; i++) begin
      adc_word = words[i];
      exp_q.push_back('{err: 1'b0, ok: 1'b1, val: vals[i]});
      prev = last_fall;
      wait_event(200, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL value_timeout frame %0d", i);
        return;
      end
      got = ev_q.pop_front();
      exp = exp_q.pop_front();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL value_%0d got %h want %h", i, got, exp);
      end
      tests++;
      if (last_fall - prev !== 100) begin
        fails++;
        $display("FAIL period_%0d got %0d want 100", i, last_fall - prev);
      end
    end
  endtask

  task automatic test_frame_err();
    bit ok;
    ev_t got, exp;
    adc_word = 16'h1ABC;
    exp_q.push_back('{err: 1'b1, ok: 1'b0, val: 12'h014});
    wait_event(200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL err_timeout no frame_err within 200 cycles");
      return;
    end
    got = ev_q.pop_front();
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL frame_err got %h want %h", got, exp);
    end
    step();
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL err_width got %b want 0", frame_err);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    ev_t got, exp;
    int bad;
    adc_word = 16'h0900;
    exp_q.push_back('{err: 1'b0, ok: 1'b1, val: 12'h100});
    wait_cs(1'b0, 200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drop_start no frame within 200 cycles");
      return;
    end
    repeat (22) step();
    enable = 1'b0;
    wait_event(200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drop_timeout frame did not complete");
      return;
    end
    got = ev_q.pop_front();
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL drop_event got %h want %h", got, exp);
    end
    bad = 0;
    for (int i = 0; i < 320; i++) begin
      step();
      if (!cs_n || !sclk) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL drop_idle got %0d active cycles want 0", bad);
    end
    tests++;
    if (ev_q.size() !== 0) begin
      fails++;
      $display("FAIL drop_extra got %0d pulses want 0", ev_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ev_t got, exp;
    int rel;
    adc_word = 16'h0555;
    enable = 1'b1;
    wait_cs(1'b0, 200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rmid_start no frame within 200 cycles");
      return;
    end
    repeat (15) step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({cs_n, sclk, busy} !== 3'b110) begin
      fails++;
      $display("FAIL rmid_async got cs_n,sclk,busy=%b want 110", {cs_n, sclk, busy});
    end
    repeat (3) step();
    tests++;
    if (ev_q.size() !== 0 || sample_valid !== 1'b0 || value !== 12'h000) begin
      fails++;
      $display("FAIL rmid_quiet got pulses=%0d valid=%b value=%h want 0 0 000",
               ev_q.size(), sample_valid, value);
    end
    adc_word = 16'h0A00;
    exp_q.push_back('{err: 1'b0, ok: 1'b1, val: 12'h200});
    rst_n = 1'b1;
    rel = cyc;
    wait_event(300, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rmid_timeout no sample after release");
      return;
    end
    got = ev_q.pop_front();
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL rmid_event got %h want %h", got, exp);
    end
    tests++;
    if (last_fall - rel !== 100) begin
      fails++;
      $display("FAIL rmid_start_delay got %0d want 100", last_fall - rel);
    end
  endtask

  task automatic test_avg4();
    logic [15:0] words[7] = '{16'h0800, 16'h0804, 16'h1ABC, 16'h0800, 16'h0804, 16'h0808, 16'h080C};
    bit ok;
    ev_t got, exp;
    exp_q.push_back('{err: 1'b1, ok: 1'b0, val: 12'h000});
    exp_q.push_back('{err: 1'b0, ok: 1'b1, val: 12'h006});
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      adc_word = words[i];
      wait_cs(1'b0, 200, ok);
      if (ok) wait_cs(1'b1, 200, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL avg_timeout frame %0d", i);
        return;
      end
    end
    repeat (2) step();
    tests++;
    if (ev_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL avg_count got %0d pulses want %0d", ev_q.size(), exp_q.size());
      return;
    end
    while (exp_q.size() != 0) begin
      got = ev_q.pop_front();
      exp = exp_q.pop_front();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL avg_event got %h want %h", got, exp);
      end
    end
  endtask

  task automatic test_exclusive();
    tests++;
    if (both_hi !== 0) begin
      fails++;
      $display("FAIL valid_err_overlap got %0d cycles want 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
`ifdef SAMPLE_AVG4_EN
    test_avg4();
`else
    test_first_frame();
    test_values();
    test_frame_err();
    test_enable_drop();
    test_reset_mid();
`endif
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
